// File: rtl/bitstream_pkg.sv
// Shared types and helpers for the stochastic bitstream blocks.
// The optional STREAM_DECODER_BIPOLAR_EN build selects the bipolar mode of sat_count in stream_decoder.
package bitstream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } decoder_state_t;

  localparam int DEFAULT_FRAME_WIDTH = 8;

  // Maps a ones count over a 2^width frame to a width-bit result (take the low width bits).
  // Bipolar results are two's complement offset by half the frame; only the top end can overflow.
  function automatic logic [31:0] sat_count(input logic [31:0] ones,
                                            input int unsigned width,
                                            input logic bipolar);
    logic [31:0] full;
    full = 32'(1) << width;
    if (bipolar) begin
      return (ones >= full) ? (full >> 1) - 32'd1 : ones - (full >> 1);
    end else begin
      return (ones >= full) ? full - 32'd1 : ones;
    end
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame sample counter: WIDTH+1 bits so it can reach 2^WIDTH; tc_o flags the sample that completes the frame.
// Also intended for aligning upstream stream generators to the same frame boundaries.
module frame_timer #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [WIDTH:0] LAST = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] FULL = {1'b1, {WIDTH{1'b0}}};

  logic [WIDTH:0] count_q;
  logic [WIDTH:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != FULL)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = en_i && (count_q == LAST);

endmodule

// File: rtl/stream_decoder.sv
// Counts ones of a unipolar bitstream over a 2^WIDTH-cycle frame and offers the result via valid/ready.
// Define STREAM_DECODER_BIPOLAR_EN for a signed result offset by 2^(WIDTH-1).
module stream_decoder
  import bitstream_pkg::*;
#(
  parameter int WIDTH = DEFAULT_FRAME_WIDTH
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             x,
  output logic [WIDTH-1:0] value,
  output logic             valid,
  input  logic             ready,
  output logic             busy
);

`ifdef STREAM_DECODER_BIPOLAR_EN
  localparam logic BIPOLAR = 1'b1;
`else
  localparam logic BIPOLAR = 1'b0;
`endif

  decoder_state_t   state_q, state_d;
  logic [WIDTH:0]   ones_q, ones_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic             timer_clr;
  logic             timer_en;
  logic             timer_tc;
  logic [WIDTH:0]   ones_total;

  frame_timer #(
    .WIDTH(WIDTH)
  ) u_frame_timer (
    .clk  (clk),
    .n_rst(n_rst),
    .clr_i(timer_clr),
    .en_i (timer_en),
    .tc_o (timer_tc)
  );

  assign ones_total = ones_q + (WIDTH + 1)'(x);

  always_comb begin
    state_d   = state_q;
    ones_d    = ones_q;
    value_d   = value_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    timer_clr = 1'b0;
    timer_en  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = COUNT;
          ones_d    = '0;
          timer_clr = 1'b1;
          busy_d    = 1'b1;
        end
      end

      COUNT: begin
        timer_en = 1'b1;
        ones_d   = ones_total;
        // The final sample is folded into the result on the same edge it is counted.
        if (timer_tc) begin
          value_d = WIDTH'(sat_count(32'(ones_total), WIDTH, BIPOLAR));
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end

      DONE: begin
        if (valid_q && ready) begin
          valid_d = 1'b0;
          if (start) begin
            state_d   = COUNT;
            ones_d    = '0;
            timer_clr = 1'b1;
            busy_d    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      ones_q  <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ones_q  <= ones_d;
      value_q <= value_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign value = value_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_stream_decoder.sv
// Scoreboard bench for stream_decoder: expected results are queued when a frame is driven
// and compared at each valid/ready handshake. Honours STREAM_DECODER_BIPOLAR_EN.
module tb_stream_decoder;

  localparam int W = 8;
  localparam int N = 1 << W;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         start;
  logic         x;
  logic         ready;
  logic         valid;
  logic         busy;
  logic [W-1:0] value;

  int           total = 0;
  int           bad = 0;
  logic [W-1:0] sb_q[$];
  bit           frame_bits[N];

  always #5 clk = ~clk;

  stream_decoder #(
    .WIDTH(W)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .start(start),
    .x    (x),
    .value(value),
    .valid(valid),
    .ready(ready),
    .busy (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s value=%0d", tag, got);
    end
  endtask

  function automatic logic [W-1:0] model(input int ones);
    int v;
`ifdef STREAM_DECODER_BIPOLAR_EN
    v = ones - N / 2;
    if (v > N / 2 - 1) v = N / 2 - 1;
`else
    v = ones;
    if (v > N - 1) v = N - 1;
`endif
    return W'(v);
  endfunction

  // mode 0: all zeros, 1: all ones, 2: alternating 1/0, 3: shuffled with exactly 64 ones
  task automatic gen_bits(input int mode);
    int ones;
    ones = 0;
    for (int k = 0; k < N; k++) begin
      case (mode)
        0:       frame_bits[k] = 1'b0;
        1:       frame_bits[k] = 1'b1;
        2:       frame_bits[k] = (k % 2 == 0);
        default: frame_bits[k] = (k < 64);
      endcase
    end
    if (mode == 3) begin
      for (int k = N - 1; k > 0; k--) begin
        int j;
        bit t;
        j = $urandom_range(k, 0);
        t = frame_bits[k];
        frame_bits[k] = frame_bits[j];
        frame_bits[j] = t;
      end
    end
    for (int k = 0; k < N; k++) ones += int'(frame_bits[k]);
    sb_q.push_back(model(ones));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller has set start (and ready, if leaving DONE); the first edge here is E0.
  task automatic count_frame(input int mode, input bit keep_start, input bit poke_starts);
    int errs;
    int busy_cnt;
    gen_bits(mode);
    step();
    if (!keep_start) start = 1'b0;
    check("busy_after_start", busy, 1);
    errs = 0;
    busy_cnt = int'(busy);
    for (int i = 0; i < N; i++) begin
      x = frame_bits[i];
      if (poke_starts) start = (i % 37 == 5);
      step();
      if (i < N - 1) begin
        if (valid) errs++;
        if (busy) busy_cnt++;
      end
    end
    start = keep_start;
    x = 1'b0;
    check("valid_at_E256", valid, 1);
    check("busy_low_at_end", busy, 0);
    check("no_early_valid", errs, 0);
    check("busy_cycles", busy_cnt, N);
  endtask

  always @(negedge clk) begin
    if (n_rst && valid && ready) begin
      int depth;
      depth = sb_q.size();
      check("sb_depth_at_handshake", int'(depth > 0), 1);
      if (depth > 0) check("sb_value", value, sb_q.pop_front());
    end
  end

  initial begin
    int errs;
    logic [W-1:0] held;

    n_rst = 1'b0;
    start = 1'b0;
    x     = 1'b0;
    ready = 1'b0;
    step();
    step();
    check("reset_value", value, 0);
    check("reset_valid", valid, 0);
    check("reset_busy", busy, 0);
    n_rst = 1'b1;
    step();

    // zeros, immediate consumer
    ready = 1'b1;
    start = 1'b1;
    count_frame(0, 1'b0, 1'b0);
    step();
    check("zeros_valid_dropped", valid, 0);

    // ones, consumer stalls 20 cycles
    ready = 1'b0;
    start = 1'b1;
    count_frame(1, 1'b0, 1'b0);
    held = value;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      start = (i == 7);
      step();
      if (!valid || value !== held) errs++;
    end
    start = 1'b0;
    check("hold_stable", errs, 0);
    check("ones_value", value, model(N));
    ready = 1'b1;
    step();
    check("valid_drop_after_ready", valid, 0);
    step();
    check("value_kept_in_idle", value, model(N));
    check("idle_not_busy", busy, 0);

    // alternating, back-to-back via start+ready in DONE
    ready = 1'b0;
    start = 1'b1;
    count_frame(2, 1'b0, 1'b0);
    ready = 1'b1;
    start = 1'b1;
    count_frame(2, 1'b0, 1'b0);
    step();
    check("b2b_done_to_idle", valid, 0);

    // shuffled stream with stray start pulses during COUNT
    start = 1'b1;
    count_frame(3, 1'b0, 1'b1);
    step();

    // asynchronous reset at cycle 100 of a frame
    start = 1'b1;
    gen_bits(1);
    step();
    start = 1'b0;
    x = 1'b1;
    repeat (100) step();
    #2;
    n_rst = 1'b0;
    #1;
    check("async_rst_value", value, 0);
    check("async_rst_valid", valid, 0);
    check("async_rst_busy", busy, 0);
    void'(sb_q.pop_back());
    x = 1'b0;
    step();
    step();
    n_rst = 1'b1;
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (valid || busy) errs++;
    end
    check("no_valid_after_abort", errs, 0);
    start = 1'b1;
    count_frame(2, 1'b0, 1'b0);
    step();

    // start held high continuously: frames repeat every 257 cycles
    ready = 1'b1;
    start = 1'b1;
    count_frame(1, 1'b1, 1'b0);
    count_frame(2, 1'b1, 1'b0);
    count_frame(3, 1'b1, 1'b0);
    start = 1'b0;
    step();
    check("continuous_end_valid", valid, 0);
    check("continuous_end_busy", busy, 0);
    check("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
